// File: rtl/wb4_sync_fifo_width_conv.sv
// wb4_sync_fifo_width_conv
// Single-clock Wishbone B4 pipelined FIFO with width conversion.
// Narrow input beats are packed LSB-lane first into wide entries, or wide
// entries are unpacked LSB-lane first into narrow output beats; equal widths
// give a plain 1:1 FIFO. Full/empty come from wrap-bit pointers.
// Optional feature: define WB4_FIFO_LEVEL_EN to add the o_level output,
// a registered count of stored wide entries.
module wb4_sync_fifo_width_conv #(
   parameter int P_DATA_I_MSB = 7,
   parameter int P_DATA_O_MSB = 31,
   parameter int P_DEPTH      = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_wb4_in_scyc,
   input  logic                    i_wb4_in_sstb,
   input  logic [P_DATA_I_MSB:0]   i_wb4_in_sdata,
   output logic                    o_wb4_in_sack,
   output logic                    o_wb4_in_sstall,
   output logic                    o_wb4_in_stgd,
   input  logic                    i_wb4_out_scyc,
   input  logic                    i_wb4_out_sstb,
   output logic                    o_wb4_out_sack,
   output logic [P_DATA_O_MSB:0]   o_wb4_out_sdata,
   output logic                    o_wb4_out_stgd,
`ifdef WB4_FIFO_LEVEL_EN
   output logic [$clog2(P_DEPTH):0] o_level,
`endif
   output logic                    o_wb4_out_sstall
);

   localparam int W_IN   = P_DATA_I_MSB + 1;
   localparam int W_OUT  = P_DATA_O_MSB + 1;
   localparam int W_MAX  = (W_IN > W_OUT) ? W_IN : W_OUT;
   localparam int W_MIN  = (W_IN > W_OUT) ? W_OUT : W_IN;
   localparam int R      = W_MAX / W_MIN;
   localparam int ADDR   = $clog2(P_DEPTH);
   localparam bit PACK   = (W_IN < W_OUT);
   localparam bit UNPACK = (W_OUT < W_IN);

   logic [ADDR:0]      r_wrPtr;
   logic [ADDR:0]      r_rdPtr;
   logic [W_MAX-1:0]   r_mem [P_DEPTH];
   logic               r_inAck;
   logic               r_outAck;
   logic [W_OUT-1:0]   r_outData;

   logic               w_empty;
   logic               w_full;
   logic               w_wrAccept;
   logic               w_rdAccept;
   logic               w_push;
   logic               w_pop;
   logic [W_MAX-1:0]   w_pushWord;
   logic [W_MAX-1:0]   w_headWord;
   logic [W_OUT-1:0]   w_rdData;

   assign w_empty = (r_wrPtr == r_rdPtr);
   assign w_full  = (r_wrPtr[ADDR-1:0] == r_rdPtr[ADDR-1:0]) &&
                    (r_wrPtr[ADDR] != r_rdPtr[ADDR]);

   assign w_wrAccept = i_wb4_in_scyc & i_wb4_in_sstb & ~o_wb4_in_sstall;
   assign w_rdAccept = i_wb4_out_scyc & i_wb4_out_sstb & ~w_empty;

   assign w_headWord = r_mem[r_rdPtr[ADDR-1:0]];

   assign o_wb4_in_stgd    = w_empty;
   assign o_wb4_out_stgd   = w_full;
   assign o_wb4_out_sstall = w_empty;
   assign o_wb4_in_sack    = r_inAck;
   assign o_wb4_out_sack   = r_outAck;
   assign o_wb4_out_sdata  = r_outData;

   generate
      if (PACK) begin : g_pack
         localparam int LANE_W = $clog2(R);
         localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R - 1);

         logic [LANE_W-1:0] r_wrLane;
         logic [W_MAX-1:0]  r_packBuf;
         logic [W_MAX-1:0]  w_packWord;
         logic              w_lastLane;

         assign w_lastLane = (r_wrLane == LAST_LANE);

         // Lanes already collected may still be written while full; only the
         // beat that would complete a word has to wait for a free entry.
         assign o_wb4_in_sstall = w_full & w_lastLane;
         assign w_push          = w_wrAccept & w_lastLane;
         assign w_pushWord      = w_packWord;

         // Merge the incoming beat into its lane of the partially built word.
         always_comb begin
            w_packWord = r_packBuf;
            w_packWord[int'(r_wrLane) * W_IN +: W_IN] = i_wb4_in_sdata;
         end

         // Write lane tracking; dropping the cycle abandons the partial word.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_wrLane  <= '0;
               r_packBuf <= '0;
            end else if (!i_wb4_in_scyc) begin
               r_wrLane  <= '0;
            end else if (w_wrAccept) begin
               r_packBuf <= w_packWord;
               r_wrLane  <= w_lastLane ? '0 : r_wrLane + LANE_W'(1);
            end
         end
      end else begin : g_wrDirect
         assign o_wb4_in_sstall = w_full;
         assign w_push          = w_wrAccept;
         assign w_pushWord      = i_wb4_in_sdata;
      end

      if (UNPACK) begin : g_unpack
         localparam int LANE_W = $clog2(R);
         localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R - 1);

         logic [LANE_W-1:0] r_rdLane;
         logic              w_lastLane;

         assign w_lastLane = (r_rdLane == LAST_LANE);
         assign w_rdData   = w_headWord[int'(r_rdLane) * W_OUT +: W_OUT];
         assign w_pop      = w_rdAccept & w_lastLane;

         // Read lane tracking; dropping the cycle restarts the head entry.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rdLane <= '0;
            end else if (!i_wb4_out_scyc) begin
               r_rdLane <= '0;
            end else if (w_rdAccept) begin
               r_rdLane <= w_lastLane ? '0 : r_rdLane + LANE_W'(1);
            end
         end
      end else begin : g_rdDirect
         assign w_rdData = w_headWord;
         assign w_pop    = w_rdAccept;
      end
   endgenerate

   // Storage array: completed wide words are written at the write address.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wrPtr[ADDR-1:0]] <= w_pushWord;
      end
   end

   // Wrap-bit pointers advance on each completed push and pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + (ADDR+1)'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + (ADDR+1)'(1);
         end
      end
   end

   // Registered acks one cycle after acceptance; read data held between reads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inAck   <= 1'b0;
         r_outAck  <= 1'b0;
         r_outData <= '0;
      end else begin
         r_inAck  <= w_wrAccept;
         r_outAck <= w_rdAccept;
         if (w_rdAccept) begin
            r_outData <= w_rdData;
         end
      end
   end

`ifdef WB4_FIFO_LEVEL_EN
   logic [ADDR:0] r_count;

   // Occupancy in wide entries, tracking pushes and pops of whole words.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR+1)'(1);
            2'b01:   r_count <= r_count - (ADDR+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_level = r_count;
`endif

endmodule

// File: tb/tb_wb4_sync_fifo_width_conv.sv
// tb_wb4_sync_fifo_width_conv
// Exercises a packing instance (8 -> 32) and an unpacking instance (32 -> 8)
// against queue-based reference models of the FIFO contents.
module tb_wb4_sync_fifo_width_conv;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   // Packing instance signals
   logic        pInCyc, pInStb, pInAck, pInStall, pInTgd;
   logic [7:0]  pInData;
   logic        pOutCyc, pOutStb, pOutAck, pOutTgd, pOutStall;
   logic [31:0] pOutData;

   // Unpacking instance signals
   logic        uInCyc, uInStb, uInAck, uInStall, uInTgd;
   logic [31:0] uInData;
   logic        uOutCyc, uOutStb, uOutAck, uOutTgd, uOutStall;
   logic [7:0]  uOutData;

`ifdef WB4_FIFO_LEVEL_EN
   logic [2:0]  pLevel;
   logic [2:0]  uLevel;
`endif

   int compareCount;
   int mismatchCount;

   // Reference models: stored wide words plus partial pack/unpack progress
   bit [31:0]   packQ[$];
   bit [7:0]    partBytes[$];
   logic [31:0] packExpData;
   bit [31:0]   unpQ[$];
   int          unpLane;
   logic [7:0]  unpExpData;

   wb4_sync_fifo_width_conv #(
      .P_DATA_I_MSB(7), .P_DATA_O_MSB(31), .P_DEPTH(DEPTH)
   ) dutPack (
      .i_clk(clk), .i_rst(rst),
      .i_wb4_in_scyc(pInCyc), .i_wb4_in_sstb(pInStb), .i_wb4_in_sdata(pInData),
      .o_wb4_in_sack(pInAck), .o_wb4_in_sstall(pInStall), .o_wb4_in_stgd(pInTgd),
      .i_wb4_out_scyc(pOutCyc), .i_wb4_out_sstb(pOutStb), .o_wb4_out_sack(pOutAck),
      .o_wb4_out_sdata(pOutData), .o_wb4_out_stgd(pOutTgd),
`ifdef WB4_FIFO_LEVEL_EN
      .o_level(pLevel),
`endif
      .o_wb4_out_sstall(pOutStall)
   );

   wb4_sync_fifo_width_conv #(
      .P_DATA_I_MSB(31), .P_DATA_O_MSB(7), .P_DEPTH(DEPTH)
   ) dutUnpack (
      .i_clk(clk), .i_rst(rst),
      .i_wb4_in_scyc(uInCyc), .i_wb4_in_sstb(uInStb), .i_wb4_in_sdata(uInData),
      .o_wb4_in_sack(uInAck), .o_wb4_in_sstall(uInStall), .o_wb4_in_stgd(uInTgd),
      .i_wb4_out_scyc(uOutCyc), .i_wb4_out_sstb(uOutStb), .o_wb4_out_sack(uOutAck),
      .o_wb4_out_sdata(uOutData), .o_wb4_out_stgd(uOutTgd),
`ifdef WB4_FIFO_LEVEL_EN
      .o_level(uLevel),
`endif
      .o_wb4_out_sstall(uOutStall)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a run that never reaches its summary
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idleInputs();
      pInCyc = 0; pInStb = 0; pInData = '0; pOutCyc = 0; pOutStb = 0;
      uInCyc = 0; uInStb = 0; uInData = '0; uOutCyc = 0; uOutStb = 0;
   endtask

   task automatic doReset(input bit keepStrobes);
      if (!keepStrobes) idleInputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idleInputs();
      packQ.delete(); partBytes.delete(); packExpData = '0;
      unpQ.delete(); unpLane = 0; unpExpData = '0;
   endtask

   task automatic checkResetState();
      checkOutput("rst p in_stgd", pInTgd, 1);
      checkOutput("rst p out_sstall", pOutStall, 1);
      checkOutput("rst p in_sstall", pInStall, 0);
      checkOutput("rst p out_stgd", pOutTgd, 0);
      checkOutput("rst p in_sack", pInAck, 0);
      checkOutput("rst p out_sack", pOutAck, 0);
      checkOutput("rst p out_sdata", pOutData, 32'h0);
      checkOutput("rst u in_stgd", uInTgd, 1);
      checkOutput("rst u out_sstall", uOutStall, 1);
      checkOutput("rst u out_sdata", {24'h0, uOutData}, 32'h0);
   endtask

   // One clock of traffic on either instance, checked against the model
   task automatic applyStimulus(input bit onUnpack, input bit wCyc, input bit wStb,
                                input logic [31:0] wData, input bit rCyc, input bit rStb);
      bit expInStall, expEmpty, expFull, wrAcc, rdAcc;
      bit [31:0] head;
      idleInputs();
      if (onUnpack) begin
         uInCyc = wCyc; uInStb = wStb; uInData = wData; uOutCyc = rCyc; uOutStb = rStb;
      end else begin
         pInCyc = wCyc; pInStb = wStb; pInData = wData[7:0]; pOutCyc = rCyc; pOutStb = rStb;
      end
      #1;
      if (onUnpack) begin
         expEmpty   = (unpQ.size() == 0);
         expFull    = (unpQ.size() == DEPTH);
         expInStall = expFull;
         checkOutput("u in_sstall", uInStall, expInStall);
         checkOutput("u out_sstall", uOutStall, expEmpty);
         checkOutput("u out_stgd", uOutTgd, expFull);
      end else begin
         expEmpty   = (packQ.size() == 0);
         expFull    = (packQ.size() == DEPTH);
         expInStall = expFull && (partBytes.size() == 3);
         checkOutput("p in_sstall", pInStall, expInStall);
         checkOutput("p in_stgd", pInTgd, expEmpty);
         checkOutput("p out_stgd", pOutTgd, expFull);
      end
      wrAcc = wCyc && wStb && !expInStall;
      rdAcc = rCyc && rStb && !expEmpty;
      @(posedge clk); #1;
      if (onUnpack) begin
         if (rdAcc) begin
            head = unpQ[0];
            unpExpData = head[unpLane*8 +: 8];
            if (unpLane == 3) begin
               void'(unpQ.pop_front());
               unpLane = 0;
            end else begin
               unpLane++;
            end
         end
         if (!rCyc) unpLane = 0;
         if (wrAcc) unpQ.push_back(wData);
         checkOutput("u in_sack", uInAck, wrAcc);
         checkOutput("u out_sack", uOutAck, rdAcc);
         checkOutput("u out_sdata", {24'h0, uOutData}, {24'h0, unpExpData});
`ifdef WB4_FIFO_LEVEL_EN
         checkOutput("u level", {29'h0, uLevel}, unpQ.size());
`endif
      end else begin
         if (rdAcc) packExpData = packQ.pop_front();
         if (!wCyc) begin
            partBytes.delete();
         end else if (wrAcc) begin
            partBytes.push_back(wData[7:0]);
            if (partBytes.size() == 4) begin
               packQ.push_back({partBytes[3], partBytes[2], partBytes[1], partBytes[0]});
               partBytes.delete();
            end
         end
         checkOutput("p in_sack", pInAck, wrAcc);
         checkOutput("p out_sack", pOutAck, rdAcc);
         checkOutput("p out_sdata", pOutData, packExpData);
`ifdef WB4_FIFO_LEVEL_EN
         checkOutput("p level", {29'h0, pLevel}, packQ.size());
`endif
      end
   endtask

   initial begin
      logic [7:0] packBytes [4];
      compareCount  = 0;
      mismatchCount = 0;
      rst = 1'b0;
      idleInputs();
      @(posedge clk); #1;

      // Reset and idle
      doReset(0);
      checkResetState();
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);

      // Directed pack: four bytes then one read
      packBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, {24'h0, packBytes[i]}, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("pack word", pOutData, 32'h44332211);

      // Fill to full, keep filling lanes, then stall on the completing beat
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 32'($urandom), 0, 0);
      checkOutput("fill full flag", pOutTgd, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 32'($urandom), 0, 0);
      checkOutput("fill 20th stalled", pInStall, 1);
      applyStimulus(0, 1, 1, 32'h5A, 0, 0);
      applyStimulus(0, 1, 1, 32'h5A, 1, 1);
      checkOutput("fill space freed", pInStall, 0);
      applyStimulus(0, 1, 1, 32'h5A, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("fill drained", pOutStall, 1);

      // Steady concurrent stream across pointer wrap
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 32'($urandom), 0, 0);
      for (int i = 0; i < 24; i++) applyStimulus(0, 1, 1, 32'($urandom), 1, (i % 4) == 3);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 1);

      // Dropped write cycle discards a partial word
      applyStimulus(0, 1, 1, 32'hAA, 0, 0);
      applyStimulus(0, 1, 1, 32'hBB, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      packBytes = '{8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, {24'h0, packBytes[i]}, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("scyc drop word", pOutData, 32'h88776655);

      // Reset in the middle of a burst
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 32'($urandom), 0, 0);
      pInCyc = 1; pInStb = 1; pInData = 8'hEE;
      doReset(1);
      checkOutput("midrst empty", pInTgd, 1);
      checkOutput("midrst in_sack", pInAck, 0);

      // Randomised pack traffic: write-heavy, then read-heavy
      for (int i = 0; i < 300; i++)
         applyStimulus(0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, 32'($urandom),
                       $urandom_range(0, 7) != 0,
                       (i < 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0));

      // Directed unpack: one word returned as four LSB-first bytes
      applyStimulus(1, 1, 1, 32'hA1B2C3D4, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 1);
      checkOutput("unpack lane0", {24'h0, uOutData}, 32'hD4);
      applyStimulus(1, 0, 0, 0, 1, 1);
      checkOutput("unpack lane1", {24'h0, uOutData}, 32'hC3);
      applyStimulus(1, 0, 0, 0, 1, 1);
      checkOutput("unpack lane2", {24'h0, uOutData}, 32'hB2);
      applyStimulus(1, 0, 0, 0, 1, 1);
      checkOutput("unpack lane3", {24'h0, uOutData}, 32'hA1);
      checkOutput("unpack empty", uOutStall, 1);

      // Randomised unpack traffic including dropped read cycles
      for (int i = 0; i < 300; i++)
         applyStimulus(1, $urandom_range(0, 7) != 0,
                       (i < 150) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0),
                       32'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
